fifo_rptr_empty: RTL and testbench

//  Read-side pointer and empty-flag generator for the async FIFO; lives entirely in the read clock domain.

---
 rtl/fifo_pkg.sv | 21 ++
 rtl/fifo_gray2bin.sv | 14 +
 rtl/fifo_rptr_empty.sv | 78 +++++++
 tb/tb_fifo_rptr_empty.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/fifo_pkg.sv
// Shared async-FIFO definitions: default address width, pointer type and Gray/binary helpers.
package fifo_pkg;

  localparam int ADDRSIZE = 4;

  typedef logic [ADDRSIZE:0] ptr_t;

  function automatic ptr_t bin2gray(input ptr_t bin);
    return (bin >> 1) ^ bin;
  endfunction

  function automatic ptr_t gray2bin(input ptr_t gray);
    ptr_t bin;
    bin[ADDRSIZE] = gray[ADDRSIZE];
    for (int i = ADDRSIZE - 1; i >= 0; i--) begin
      bin[i] = bin[i+1] ^ gray[i];
    end
    return bin;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Parameterized Gray-to-binary converter; purely combinational XOR-prefix.
module fifo_gray2bin #(
  parameter int W = 5
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the parity of the Gray bits at and above it.
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_rptr_empty.sv
// Read-side pointer, registered empty flag and sticky underflow for the async FIFO.
// Optional read-side level / almost-empty enabled by defining FIFO_RLEVEL_EN.
module fifo_rptr_empty
  import fifo_pkg::*;
#(
  parameter int ADDRSIZE      = fifo_pkg::ADDRSIZE,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                rclk,
  input  logic                rrst,
  input  logic                rinc,
  input  logic [ADDRSIZE:0]   rq2_wptr,
  input  logic                rerr_clr,
  output logic [ADDRSIZE-1:0] raddr,
  output logic [ADDRSIZE:0]   rptr,
  output logic                rempty,
  output logic                rerr,
  output logic [ADDRSIZE:0]   rlevel,
  output logic                ralmost_empty
);

  logic [ADDRSIZE:0] rbin;
  logic [ADDRSIZE:0] rbinnext;
  logic [ADDRSIZE:0] rgraynext;
  logic              rd_en;
  logic              rerr_set;

  // Read handshake: rinc is a request; an entry is consumed on a rising rclk
  // edge only when rinc=1 and rempty=0. rinc while empty is an underflow.
  assign rd_en     = rinc & ~rempty;
  assign rerr_set  = rinc & rempty;
  assign rbinnext  = rbin + {{ADDRSIZE{1'b0}}, rd_en};
  assign rgraynext = (rbinnext >> 1) ^ rbinnext;
  assign raddr     = rbin[ADDRSIZE-1:0];

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rbin   <= '0;
      rptr   <= '0;
      rempty <= 1'b1;
      rerr   <= 1'b0;
    end else begin
      rbin   <= rbinnext;
      rptr   <= rgraynext;
      // Look-ahead compare sets empty on the same edge the last entry leaves.
      rempty <= (rgraynext == rq2_wptr);
      rerr   <= rerr_set | (rerr & ~rerr_clr);
    end
  end

`ifdef FIFO_RLEVEL_EN
  localparam logic [ADDRSIZE:0] THRESH = AEMPTY_THRESH[ADDRSIZE:0];

  logic [ADDRSIZE:0] wbin;
  logic [ADDRSIZE:0] level_next;

  fifo_gray2bin #(.W(ADDRSIZE + 1)) u_wgray2bin (
    .gray (rq2_wptr),
    .bin  (wbin)
  );

  assign level_next = wbin - rbinnext;

  always_ff @(posedge rclk) begin
    if (rrst) begin
      rlevel        <= '0;
      ralmost_empty <= 1'b1;
    end else begin
      rlevel        <= level_next;
      ralmost_empty <= (level_next <= THRESH);
    end
  end
`else
  assign rlevel        = '0;
  assign ralmost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rptr_empty.sv
// Directed self-checking bench for fifo_rptr_empty (ADDRSIZE=4, AEMPTY_THRESH=2).
module tb_fifo_rptr_empty;

  localparam int AW = 4;
`ifdef FIFO_RLEVEL_EN
  localparam bit LVL = 1'b1;
`else
  localparam bit LVL = 1'b0;
`endif

  // clock / reset
  logic          rclk = 1'b0;
  logic          rrst = 1'b0;
  logic          rinc = 1'b0;
  logic [AW:0]   rq2_wptr = '0;
  logic          rerr_clr = 1'b0;
  logic [AW-1:0] raddr;
  logic [AW:0]   rptr;
  logic          rempty;
  logic          rerr;
  logic [AW:0]   rlevel;
  logic          ralmost_empty;

  always #5 rclk = ~rclk;

  fifo_rptr_empty #(.ADDRSIZE(AW), .AEMPTY_THRESH(2)) dut (
    .rclk          (rclk),
    .rrst          (rrst),
    .rinc          (rinc),
    .rq2_wptr      (rq2_wptr),
    .rerr_clr      (rerr_clr),
    .raddr         (raddr),
    .rptr          (rptr),
    .rempty        (rempty),
    .rerr          (rerr),
    .rlevel        (rlevel),
    .ralmost_empty (ralmost_empty)
  );

  // scoreboard
  int n_tests = 0;
  int n_fail  = 0;
  logic [AW-1:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [AW:0] gray(input int b);
    logic [AW:0] v;
    v = b[AW:0];
    return (v >> 1) ^ v;
  endfunction

  // driver tasks
  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic do_reset();
    rrst = 1'b1; rinc = 1'b0; rerr_clr = 1'b0; rq2_wptr = '0;
    step();
    rrst = 1'b0;
  endtask

  initial begin
    // 1 reset
    do_reset();
    check("rst_rempty", rempty, 1);
    check("rst_rptr", rptr, 0);
    check("rst_raddr", raddr, 0);
    check("rst_rerr", rerr, 0);
    check("rst_rlevel", rlevel, 0);
    check("rst_ralmost", ralmost_empty, LVL ? 1 : 0);

    // 2 three entries, drain, underflow
    rq2_wptr = 5'b00010;
    step();
    check("t2_not_empty", rempty, 0);
    check("t2_level3", rlevel, LVL ? 3 : 0);
    check("t2_almost3", ralmost_empty, 0);
    rinc = 1'b1;
    for (int i = 0; i < 3; i++) begin
      check("t2_raddr_pre", raddr, i);
      step();
    end
    check("t2_raddr3", raddr, 3);
    check("t2_rptr", rptr, 5'b00010);
    check("t2_empty", rempty, 1);
    check("t2_rerr0", rerr, 0);
    check("t2_level0", rlevel, 0);
    check("t2_almost0", ralmost_empty, LVL ? 1 : 0);
    step();
    check("t2_uf_raddr", raddr, 3);
    check("t2_uf_rptr", rptr, 5'b00010);
    check("t2_uf_rerr", rerr, 1);

    // 3 sticky error, clear, set-wins
    rinc = 1'b0;
    step();
    check("t3_hold", rerr, 1);
    rerr_clr = 1'b1;
    step();
    check("t3_clr", rerr, 0);
    rinc = 1'b1;
    step();
    check("t3_set_wins", rerr, 1);
    rinc = 1'b0;
    step();
    check("t3_clr2", rerr, 0);
    rerr_clr = 1'b0;

    // 4 wrap through 32 reads with writer one step ahead
    do_reset();
    rq2_wptr = gray(1);
    step();
    check("t4_not_empty", rempty, 0);
    rinc = 1'b1;
    for (int i = 0; i < 32; i++) begin
      exp_q.push_back(i[AW-1:0]);
      rq2_wptr = gray((i < 31) ? i + 2 : 32);
      check("t4_raddr", raddr, exp_q.pop_front());
      step();
      if (i == 30) check("t4_rptr_31", rptr, 5'b10000);
      if (i < 31) check("t4_empty_lo", rempty, 0);
    end
    rinc = 1'b0;
    check("t4_rptr_end", rptr, 0);
    check("t4_raddr_end", raddr, 0);
    check("t4_empty_end", rempty, 1);
    check("t4_rerr", rerr, 0);

    // 5 level and almost-empty
    do_reset();
    rq2_wptr = 5'b11000;
    step();
    check("t5_level16", rlevel, LVL ? 16 : 0);
    check("t5_almost16", ralmost_empty, 0);
    check("t5_not_empty", rempty, 0);
    rinc = 1'b1;
    for (int i = 0; i < 13; i++) step();
    check("t5_level3", rlevel, LVL ? 3 : 0);
    check("t5_almost3", ralmost_empty, 0);
    step();
    rinc = 1'b0;
    check("t5_level2", rlevel, LVL ? 2 : 0);
    check("t5_almost2", ralmost_empty, LVL ? 1 : 0);
    check("t5_raddr14", raddr, 14);

    // 6 reset mid-operation
    do_reset();
    rq2_wptr = 5'b01101;
    step();
    rinc = 1'b1;
    for (int i = 0; i < 7; i++) step();
    check("t6_raddr7", raddr, 7);
    check("t6_not_empty", rempty, 0);
    rrst = 1'b1;
    step();
    rrst = 1'b0;
    rinc = 1'b0;
    check("t6_raddr", raddr, 0);
    check("t6_rptr", rptr, 0);
    check("t6_empty", rempty, 1);
    check("t6_rerr", rerr, 0);
    check("t6_level", rlevel, 0);

    // report
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
